// File: rtl/prog_delay_if.sv
// rtl/prog_delay_if.sv - configuration and sample stream bundle for the programmable delay line
interface prog_delay_if #(
  parameter int WIDTH = 8,
  parameter int DEL_W = 5
);
  logic             cfg_we;
  logic [DEL_W-1:0] del_cfg;
  logic [WIDTH-1:0] din;
  logic             din_vld;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             busy;
  logic [DEL_W-1:0] cur_del;

  modport master (
    output cfg_we, del_cfg, din, din_vld,
    input  dout, dout_vld, busy, cur_del
  );

  modport slave (
    input  cfg_we, del_cfg, din, din_vld,
    output dout, dout_vld, busy, cur_del
  );
endinterface

// File: rtl/prog_delay.sv
// rtl/prog_delay.sv - runtime-programmable ring-buffer delay line; PROG_DELAY_ZERO_EN enables zero-delay bypass
module prog_delay #(
  parameter int WIDTH   = 8,
  parameter int MAX_DEL = 16,
  parameter int DEF_DEL = 1,
  parameter int DEL_W   = $clog2(MAX_DEL + 1)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  prog_delay_if.slave bus
);

  localparam int AW = (MAX_DEL > 1) ? $clog2(MAX_DEL) : 1;
  localparam logic [DEL_W-1:0] MAX_DEL_V = DEL_W'(MAX_DEL);
  localparam logic [DEL_W-1:0] DEF_DEL_V = DEL_W'(DEF_DEL);
  localparam logic [DEL_W:0]   MAX_DEL_X = (DEL_W + 1)'(MAX_DEL);
`ifdef PROG_DELAY_ZERO_EN
  localparam logic [DEL_W-1:0] MIN_DEL_V = '0;
`else
  localparam logic [DEL_W-1:0] MIN_DEL_V = DEL_W'(1);
`endif

  typedef enum logic {FILL, RUN} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_addr;
  logic [DEL_W-1:0] cnt_q, cnt_d;
  logic [DEL_W-1:0] cur_del_q, cur_del_d;
  logic [DEL_W-1:0] del_clamped;
  logic [DEL_W:0]   ptr_x, del_x;
  logic [WIDTH:0]   mem_q [MAX_DEL];
  logic [WIDTH:0]   rd_word;

  always_comb begin
    del_clamped = bus.del_cfg;
    if (bus.del_cfg > MAX_DEL_V) begin
      del_clamped = MAX_DEL_V;
    end else if (bus.del_cfg == '0) begin
      del_clamped = MIN_DEL_V;
    end
  end

  // Read slot sits cur_del entries behind the write pointer; a delay of
  // MAX_DEL lands on the slot about to be overwritten.
  always_comb begin
    ptr_x = (DEL_W + 1)'(wr_ptr_q);
    del_x = (DEL_W + 1)'(cur_del_q);
    if (ptr_x >= del_x) begin
      rd_addr = AW'(ptr_x - del_x);
    end else begin
      rd_addr = AW'(ptr_x + MAX_DEL_X - del_x);
    end
  end

  assign rd_word = mem_q[rd_addr];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_del_d = cur_del_q;
    wr_ptr_d  = (wr_ptr_q == AW'(MAX_DEL - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (bus.cfg_we) begin
      cur_del_d = del_clamped;
      cnt_d     = '0;
      state_d   = FILL;
    end else if (state_q == FILL) begin
      if (cnt_q == cur_del_q - 1'b1) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      cur_del_q <= DEF_DEL_V;
      wr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_del_q <= cur_del_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // Storage is free-running and unreset; FILL gating keeps stale slots hidden.
  always_ff @(posedge clk_i) begin
    mem_q[wr_ptr_q] <= {bus.din, bus.din_vld};
  end

  always_comb begin
    bus.dout     = '0;
    bus.dout_vld = 1'b0;
    bus.busy     = (state_q == FILL);
    bus.cur_del  = cur_del_q;
    if (state_q == RUN) begin
      {bus.dout, bus.dout_vld} = rd_word;
    end
`ifdef PROG_DELAY_ZERO_EN
    if (cur_del_q == '0) begin
      bus.dout     = bus.din;
      bus.dout_vld = bus.din_vld;
      bus.busy     = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_prog_delay.sv
// tb/tb_prog_delay.sv - scoreboard bench for prog_delay
module tb_prog_delay;
  localparam int WIDTH   = 8;
  localparam int MAX_DEL = 16;
  localparam int DEF_DEL = 1;
  localparam int DEL_W   = $clog2(MAX_DEL + 1);

  typedef struct {
    logic [WIDTH-1:0] data;
    int               due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_delay_if #(.WIDTH(WIDTH), .DEL_W(DEL_W)) dif ();

  prog_delay #(
    .WIDTH(WIDTH), .MAX_DEL(MAX_DEL), .DEF_DEL(DEF_DEL), .DEL_W(DEL_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (dif)
  );

  exp_t             exp_q[$];
  exp_t             mon_e;
  int               n_vec = 0;
  int               n_bad = 0;
  int               cyc = 0;
  int               model_del = 0;
  int               fill_start = 0;
  int               pend_del = 0;
  bit               pend = 1'b0;
  bit               mon_en = 1'b0;
  bit               exp_busy;
  logic [WIDTH-1:0] ramp = 8'd1;
  logic [3:0]       vld_pat = 4'b1101;

  function automatic int clamp(input int d);
    if (d > MAX_DEL) return MAX_DEL;
`ifdef PROG_DELAY_ZERO_EN
    return d;
`else
    return (d == 0) ? 1 : d;
`endif
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // One clock of stimulus; samples issued in a cfg/reset cycle are lost
  // unless the line is a bypass, and anything due after the edge is dropped.
  task automatic step(input logic [WIDTH-1:0] d, input logic v, input logic we,
                      input logic [DEL_W-1:0] cfg, input logic r);
    exp_t e;
    dif.din     = d;
    dif.din_vld = v;
    dif.cfg_we  = we;
    dif.del_cfg = cfg;
    rst         = r;
    if (mon_en && v && cyc >= fill_start && (!(we || r) || model_del == 0)) begin
      e.data = d;
      e.due  = cyc + model_del;
      exp_q.push_back(e);
    end
    if (we || r) begin
      pend     = 1'b1;
      pend_del = r ? DEF_DEL : clamp(int'(cfg));
      while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
    end
    @(posedge clk);
    cyc++;
    if (pend) begin
      model_del  = pend_del;
      fill_start = cyc;
      pend       = 1'b0;
      mon_en     = 1'b1;
    end
    #1;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      step(ramp, 1'b1, 1'b0, '0, 1'b0);
      ramp++;
    end
  endtask

  task automatic pattern(input int n);
    for (int i = 0; i < n; i++) begin
      step(ramp, vld_pat[i % 4], 1'b0, '0, 1'b0);
      ramp++;
    end
  endtask

  task automatic cfg(input logic [DEL_W-1:0] d);
    step(ramp, 1'b1, 1'b1, d, 1'b0);
    ramp++;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_busy = (cyc < fill_start + model_del);
      chk("busy", int'(dif.busy), int'(exp_busy));
      chk("cur_del", int'(dif.cur_del), model_del);
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL missing_out: got nothing by cycle %0d, expected data %0d due cycle %0d",
                 cyc, exp_q[0].data, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (dif.dout_vld === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
          n_bad++;
          $display("FAIL unexpected_vld: got dout_vld=1 data %0d at cycle %0d, expected dout_vld=0",
                   dif.dout, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (dif.dout !== mon_e.data) begin
            n_bad++;
            $display("FAIL dout_data: got %0d, expected %0d (cycle %0d)", dif.dout, mon_e.data, cyc);
          end
        end
      end else if (dif.dout_vld !== 1'b0) begin
        n_vec++;
        n_bad++;
        $display("FAIL dout_vld_x: got %b, expected 0 or 1 (cycle %0d)", dif.dout_vld, cyc);
      end
    end
  end

  initial begin
    // 1: reset with default delay, ramp
    step(8'd0, 1'b0, 1'b0, '0, 1'b1);
    chk("rst_busy", int'(dif.busy), 1);
    chk("rst_dout_vld", int'(dif.dout_vld), 0);
    chk("rst_dout", int'(dif.dout), 0);
    chk("rst_cur_del", int'(dif.cur_del), DEF_DEL);
    stream(10);
    // 2: reconfigure to 5 while streaming
    cfg(5'd5);
    chk("cfg5_cur_del", int'(dif.cur_del), 5);
    stream(20);
    // 3: max delay and over-range request, through pointer wrap
    cfg(5'd16);
    stream(40);
    cfg(5'd31);
    chk("cfg31_clamp", int'(dif.cur_del), 16);
    stream(40);
    cfg(5'd17);
    chk("cfg17_clamp", int'(dif.cur_del), 16);
    stream(20);
    // 4: back-to-back reconfig, then reset colliding with cfg_we
    cfg(5'd3);
    cfg(5'd7);
    chk("cfg7_cur_del", int'(dif.cur_del), 7);
    stream(15);
    step(ramp, 1'b1, 1'b1, 5'd9, 1'b1);
    ramp++;
    chk("collide_cur_del", int'(dif.cur_del), DEF_DEL);
    chk("collide_busy", int'(dif.busy), 1);
    stream(10);
    // 5: valid pattern 1,0,1,1 at delay 4
    cfg(5'd4);
    pattern(16);
    // 6: zero request, then leave it
    cfg(5'd0);
`ifdef PROG_DELAY_ZERO_EN
    chk("zero_cur_del", int'(dif.cur_del), 0);
`else
    chk("zero_cur_del", int'(dif.cur_del), 1);
`endif
    stream(10);
    cfg(5'd2);
    stream(10);
    for (int i = 0; i < 24; i++) step(8'd0, 1'b0, 1'b0, '0, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
